// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// req/ack memory handshake with timeout, sticky illegal-opcode and fault flags.
module multicycle_control #(
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 12,
  parameter bit IMM_ALU     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       writereg,
  output logic [2:0] selwsource,
  output logic [1:0] selregdest,
  output logic       selimregb,
  output logic       selalushift,
  output logic [2:0] aluop,
  output logic [1:0] shiftop,
  output logic [1:0] selbrjumpz,
  output logic [1:0] selpctype,
  output logic [2:0] compop,
  output logic       unsig,
  output logic       busy,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_FWAIT  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LW, K_SW, K_BR, K_BAD
  } kind_t;

  typedef struct packed {
    logic [2:0] selwsource;
    logic [1:0] selregdest;
    logic       selimregb;
    logic       selalushift;
    logic [2:0] aluop;
    logic [1:0] shiftop;
    logic [1:0] selbrjumpz;
    logic [1:0] selpctype;
    logic [2:0] compop;
    logic       unsig;
  } ctrl_t;

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);

  state_t          st, nst;
  logic [TO_W-1:0] cnt, cnt_n;
  logic [5:0]      dop, dfn, dop_q, dfn_q;
  logic            ill_n, flt_n;
  kind_t           kind;
  ctrl_t           c, ctl_q;

  // Live IR fields in DECODE, latched copy for the rest of the instruction
  assign dop = (st == S_DECODE) ? op : dop_q;
  assign dfn = (st == S_DECODE) ? fn : dfn_q;

  always_comb begin
    c    = '0;
    kind = K_BAD;
    unique case (dop)
      6'b000000: begin
        kind         = K_ALU;
        c.selregdest = 2'b01;
        unique case (dfn)
          6'b000100: begin c.selalushift = 1'b1; c.shiftop = 2'b10; end
          6'b000110: begin c.selalushift = 1'b1; c.shiftop = 2'b00; end
          6'b000111: begin c.selalushift = 1'b1; c.shiftop = 2'b01; end
          6'b001000: begin
            kind         = K_BR;
            c.selregdest = 2'b00;
            c.selbrjumpz = 2'b01;
            c.selpctype  = 2'b01;
          end
          6'b100000: c.aluop = 3'b010;
          6'b100001: begin c.aluop = 3'b010; c.unsig = 1'b1; end
          6'b100010: c.aluop = 3'b110;
          6'b100011: begin c.aluop = 3'b110; c.unsig = 1'b1; end
          6'b100100: c.aluop = 3'b000;
          6'b100101: c.aluop = 3'b001;
          6'b100110: c.aluop = 3'b101;
          6'b100111: c.aluop = 3'b100;
          default: begin kind = K_BAD; c = '0; end
        endcase
      end
      6'b000010: begin
        kind         = K_BR;
        c.selbrjumpz = 2'b01;
        c.selpctype  = 2'b10;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        kind         = K_BR;
        c.selbrjumpz = 2'b10;
        unique case (dop[1:0])
          2'b00:   c.compop = 3'b000;
          2'b01:   c.compop = 3'b101;
          2'b10:   c.compop = 3'b010;
          default: c.compop = 3'b011;
        endcase
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110: begin
        if (IMM_ALU) begin
          kind        = K_ALU;
          c.selimregb = 1'b1;
          c.unsig     = (dop == 6'b001001);
          unique case (dop[2:0])
            3'b100:  c.aluop = 3'b000;
            3'b101:  c.aluop = 3'b001;
            3'b110:  c.aluop = 3'b101;
            default: c.aluop = 3'b010;
          endcase
        end
      end
      6'b100011: begin
        kind         = K_LW;
        c.aluop      = 3'b010;
        c.selimregb  = 1'b1;
        c.selwsource = 3'b001;
      end
      6'b101011: begin
        kind        = K_SW;
        c.aluop     = 3'b010;
        c.selimregb = 1'b1;
      end
      default: kind = K_BAD;
    endcase
  end

  always_comb begin
    nst   = st;
    cnt_n = '0;
    ill_n = illegal;
    flt_n = fault;
    unique case (st)
      // mem_req is issued on entry, so an idle FETCH after reset waits a cycle
      S_FETCH: if (mem_req) nst = S_FWAIT;
      S_FWAIT, S_MEMRD, S_MEMWR: begin
        if (mem_ack) begin
          if (st == S_FWAIT)      nst = S_DECODE;
          else if (st == S_MEMRD) nst = S_WB;
          else                    nst = S_FETCH;
        end else if (cnt == LIMIT) begin
          nst   = S_HALT;
          flt_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (kind == K_BAD) begin
          nst   = S_HALT;
          ill_n = 1'b1;
        end else if (kind == K_BR) begin
          nst = S_BRANCH;
        end else begin
          nst = S_EXEC;
        end
      end
      S_EXEC: begin
        if (kind == K_LW)      nst = S_MEMRD;
        else if (kind == K_SW) nst = S_MEMWR;
        else                   nst = S_WB;
      end
      S_WB, S_BRANCH: nst = S_FETCH;
      default: nst = S_HALT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st       <= S_FETCH;
      cnt      <= '0;
      dop_q    <= '0;
      dfn_q    <= '0;
      illegal  <= 1'b0;
      fault    <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      pc_write <= 1'b0;
      writereg <= 1'b0;
      busy     <= 1'b0;
      ctl_q    <= '0;
    end else begin
      st       <= nst;
      cnt      <= cnt_n;
      dop_q    <= dop;
      dfn_q    <= dfn;
      illegal  <= ill_n;
      fault    <= flt_n;
      mem_req  <= nst inside {S_FETCH, S_FWAIT, S_MEMRD, S_MEMWR};
      mem_we   <= (nst == S_MEMWR);
      pc_write <= (nst == S_BRANCH);
      writereg <= (nst == S_WB);
      busy     <= (nst != S_FETCH);
      ctl_q    <= (nst inside {S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_BRANCH})
                  ? c : '0;
    end
  end

  // IR/PC strobes coincide with the ack so the IR captures the data while valid
  assign ir_load     = (st == S_FWAIT) && mem_ack;
  assign pc_inc      = (st == S_FWAIT) && mem_ack;
  assign state       = st;
  assign selwsource  = ctl_q.selwsource;
  assign selregdest  = ctl_q.selregdest;
  assign selimregb   = ctl_q.selimregb;
  assign selalushift = ctl_q.selalushift;
  assign aluop       = ctl_q.aluop;
  assign shiftop     = ctl_q.shiftop;
  assign selbrjumpz  = ctl_q.selbrjumpz;
  assign selpctype   = ctl_q.selpctype;
  assign compop      = ctl_q.compop;
  assign unsig       = ctl_q.unsig;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-opcode vector table plus
// hand-written wait, timeout, illegal and reset sequences.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op, fn;
  logic       mem_ack;
  logic       mem_req, mem_we, ir_load, pc_inc, pc_write, writereg;
  logic [2:0] selwsource, aluop, compop;
  logic [1:0] selregdest, shiftop, selbrjumpz, selpctype;
  logic       selimregb, selalushift, unsig, busy, illegal, fault;
  logic [3:0] state;

  multicycle_control dut (
    .clock(clock), .reset(reset), .op(op), .fn(fn), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_write(pc_write), .writereg(writereg),
    .selwsource(selwsource), .selregdest(selregdest),
    .selimregb(selimregb), .selalushift(selalushift), .aluop(aluop),
    .shiftop(shiftop), .selbrjumpz(selbrjumpz), .selpctype(selpctype),
    .compop(compop), .unsig(unsig), .busy(busy), .illegal(illegal),
    .fault(fault), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [19:0] ctl;
    int          lat;
    int          wr;
    int          pcw;
    int          we;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  logic [19:0] ctl_now;
  logic [32:0] all_out;
  assign ctl_now = {selwsource, selregdest, selimregb, selalushift, aluop,
                    shiftop, selbrjumpz, selpctype, compop, unsig};
  assign all_out = {mem_req, mem_we, ir_load, pc_inc, pc_write, writereg,
                    ctl_now, busy, illegal, fault, state};

  int r_lat, r_wr, r_pcw, r_we, r_irl, r_pci, r_dreq;
  logic [19:0] r_ctl;

  function automatic logic [19:0] mk(
    input logic [2:0] ws, input logic [1:0] rd, input logic imb,
    input logic sas, input logic [2:0] alu, input logic [1:0] sh,
    input logic [1:0] bj, input logic [1:0] pt, input logic [2:0] cmp,
    input logic u);
    return {ws, rd, imb, sas, alu, sh, bj, pt, cmp, u};
  endfunction

  task automatic add(input logic [5:0] o, input logic [5:0] f,
                     input logic [19:0] c, input int l, input int w,
                     input int p, input int e);
    vt.push_back('{o, f, c, l, w, p, e});
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 5; i++) begin
      if (mem_req) break;
      step();
    end
    chk("fetch req", mem_req, 1);
  endtask

  // One instruction from a FETCH with mem_req up; hold = unacked data cycles
  task automatic run(input logic [5:0] o, input logic [5:0] f,
                     input int hold);
    bit fetched = 0;
    int dq = 0;
    op = o; fn = f;
    r_lat = 0; r_wr = 0; r_pcw = 0; r_we = 0;
    r_irl = 0; r_pci = 0; r_dreq = 0; r_ctl = '0;
    for (int c = 1; c <= 40; c++) begin
      if (fetched && mem_req) begin
        mem_ack = (dq == hold);
        dq++;
        r_dreq++;
      end else begin
        mem_ack = mem_req;
      end
      #1;
      if (ir_load) begin r_irl++; fetched = 1; end
      if (pc_inc) r_pci++;
      step();
      r_ctl |= ctl_now;
      if (writereg) r_wr++;
      if (pc_write) r_pcw++;
      if (mem_we) r_we++;
      if (!busy) begin r_lat = c; break; end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op = '0; fn = '0; mem_ack = 1'b0;
    add(6'h00, 6'b100000, mk(0,1,0,0,2,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b100001, mk(0,1,0,0,2,0,0,0,0,1), 5, 1, 0, 0);
    add(6'h00, 6'b100010, mk(0,1,0,0,6,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b100011, mk(0,1,0,0,6,0,0,0,0,1), 5, 1, 0, 0);
    add(6'h00, 6'b100100, mk(0,1,0,0,0,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b100101, mk(0,1,0,0,1,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b100110, mk(0,1,0,0,5,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b100111, mk(0,1,0,0,4,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b000100, mk(0,1,0,1,0,2,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b000110, mk(0,1,0,1,0,0,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b000111, mk(0,1,0,1,0,1,0,0,0,0), 5, 1, 0, 0);
    add(6'h00, 6'b001000, mk(0,0,0,0,0,0,1,1,0,0), 4, 0, 1, 0);
    add(6'b000010, 6'h00, mk(0,0,0,0,0,0,1,2,0,0), 4, 0, 1, 0);
    add(6'b000100, 6'h00, mk(0,0,0,0,0,0,2,0,0,0), 4, 0, 1, 0);
    add(6'b000101, 6'h00, mk(0,0,0,0,0,0,2,0,5,0), 4, 0, 1, 0);
    add(6'b000110, 6'h00, mk(0,0,0,0,0,0,2,0,2,0), 4, 0, 1, 0);
    add(6'b000111, 6'h00, mk(0,0,0,0,0,0,2,0,3,0), 4, 0, 1, 0);
    add(6'b001000, 6'h00, mk(0,0,1,0,2,0,0,0,0,0), 5, 1, 0, 0);
    add(6'b001001, 6'h00, mk(0,0,1,0,2,0,0,0,0,1), 5, 1, 0, 0);
    add(6'b001100, 6'h00, mk(0,0,1,0,0,0,0,0,0,0), 5, 1, 0, 0);
    add(6'b001101, 6'h00, mk(0,0,1,0,1,0,0,0,0,0), 5, 1, 0, 0);
    add(6'b001110, 6'h00, mk(0,0,1,0,5,0,0,0,0,0), 5, 1, 0, 0);
    add(6'b100011, 6'h00, mk(1,0,1,0,2,0,0,0,0,0), 6, 1, 0, 0);
    add(6'b101011, 6'h00, mk(0,0,1,0,2,0,0,0,0,0), 5, 0, 0, 1);

    #3;
    chk("reset outputs", all_out, 0);
    repeat (2) @(negedge clock);
    chk("reset held", all_out, 0);
    reset = 1'b0;
    chk("idle busy", busy, 0);
    step();
    wait_req();

    foreach (vt[i]) begin
      run(vt[i].op, vt[i].fn, 0);
      chk($sformatf("v%0d ctl", i), r_ctl, vt[i].ctl);
      chk($sformatf("v%0d lat", i), r_lat, vt[i].lat);
      chk($sformatf("v%0d wr", i), r_wr, vt[i].wr);
      chk($sformatf("v%0d pcw", i), r_pcw, vt[i].pcw);
      chk($sformatf("v%0d we", i), r_we, vt[i].we);
      chk($sformatf("v%0d irl", i), {r_irl, r_pci}, {32'd1, 32'd1});
      chk($sformatf("v%0d flags", i), {illegal, fault}, 2'b00);
    end

    run(6'b100011, 6'h00, 3);
    chk("lw wait req", r_dreq, 4);
    chk("lw wait lat", r_lat, 9);
    chk("lw wait wr", r_wr, 1);
    chk("lw wait ctl", r_ctl, mk(1,0,1,0,2,0,0,0,0,0));

    op = 6'h00; fn = 6'b100000; mem_ack = 1'b0;
    step();
    repeat (11) step();
    chk("to last wait", {state, mem_req, fault}, {4'd1, 2'b10});
    step();
    chk("to halt", {state, mem_req, fault, busy}, {4'd8, 3'b011});
    mem_ack = 1'b1;
    repeat (3) step();
    chk("halt ack ignored", {state, ir_load, writereg}, {4'd8, 2'b00});
    mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async reset", all_out, 0);
    @(negedge clock) reset = 1'b0;
    step();
    wait_req();

    step();
    repeat (11) step();
    mem_ack = 1'b1;
    #1 chk("limit ack irl", ir_load, 1);
    step();
    mem_ack = 1'b0;
    chk("limit ack wins", {state, fault}, {4'd2, 1'b0});
    for (int i = 0; i < 10 && busy; i++) step();
    chk("limit ack done", {busy, fault, mem_req}, 3'b001);

    run(6'b111111, 6'h00, 0);
    chk("ill op", {state, illegal, fault, busy, writereg},
        {4'd8, 4'b1010});
    #2 reset = 1'b1;
    #1 chk("ill reset", all_out, 0);
    @(negedge clock) reset = 1'b0;
    step();
    wait_req();
    run(6'h00, 6'b000000, 0);
    chk("ill fn", {state, illegal}, {4'd8, 1'b1});
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    step();
    wait_req();

    op = 6'b100011; mem_ack = 1'b0;
    repeat (4) step();
    chk("mid access req", {state, mem_req}, {4'd1, 1'b1});
    #2 reset = 1'b1;
    #1 chk("mid access reset", all_out, 0);
    @(negedge clock) reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
